// File: rtl/rsa_pkg.sv
// Shared definitions for the rsa_unit operand loader: FSM states and operand addresses.
package rsa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] SEL_P     = 2'd0;
  localparam logic [1:0] SEL_E     = 2'd1;
  localparam logic [1:0] SEL_M     = 2'd2;
  localparam logic [1:0] SEL_CONST = 2'd3;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for a pad-level signal with a one-cycle rising-edge pulse.
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic rise
);

  logic sync1, sync2, hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= level;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign rise = sync2 & ~hist;

endmodule

// File: rtl/rsa_operand_loader.sv
// Sequenced operand capture for rsa_unit: loads P/E/M/Const from a shared bus,
// launches the core, waits for end-of-conversion and holds the result.
module rsa_operand_loader
  import rsa_pkg::*;
#(
  parameter int WIDTH          = DEFAULT_WIDTH,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] data_in,
  input  logic [1:0]       sel,
  input  logic             wr_strobe,
  input  logic             start_req,
  input  logic             rsa_eoc,
  input  logic [WIDTH-1:0] rsa_c,
  output logic [WIDTH-1:0] op_p,
  output logic [WIDTH-1:0] op_e,
  output logic [WIDTH-1:0] op_m,
  output logic [WIDTH-1:0] op_const,
  output logic             rsa_en,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             busy,
  output logic             err
);

  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT_CYCLES);

  state_t                 state, state_next;
  logic [3:0][WIDTH-1:0]  ops;
  logic [3:0]             mask, mask_next, wr_bit;
  logic [TW-1:0]          tcnt;
  logic                   eoc_hist;
  logic                   err_next;
  logic                   wr_pulse, start_pulse;
  logic                   wr_ev, start_ev, wr_ok, start_ok;
  logic                   in_run, eoc_rise, timeout_hit;

  sync_edge_detect u_wr_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .level (wr_strobe),
    .rise  (wr_pulse)
  );

  sync_edge_detect u_start_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .level (start_req),
    .rise  (start_pulse)
  );

  // A write in the same cycle as a start counts toward the start's mask check.
  always_comb begin
    in_run      = (state == RUN);
    wr_ev       = wr_pulse & en;
    start_ev    = start_pulse & en;
    wr_ok       = wr_ev & ~in_run;
    wr_bit      = wr_ok ? (4'b0001 << sel) : '0;
    mask_next   = mask | wr_bit;
    start_ok    = start_ev & ~in_run & (mask_next == 4'b1111);
    eoc_rise    = rsa_eoc & ~eoc_hist;
    timeout_hit = (TIMEOUT_CYCLES > 0) && in_run && (tcnt == T_LAST);
  end

  always_comb begin
    state_next = state;
    err_next   = err;
    if (!en) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (start_ok) state_next = RUN;
        RUN: begin
          if (eoc_rise)         state_next = DONE;
          else if (timeout_hit) state_next = IDLE;
        end
        DONE: begin
          if (start_ok)   state_next = RUN;
          else if (wr_ok) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
    // Any start that is not accepted is an error, whatever the state.
    if (start_ok)
      err_next = 1'b0;
    else if ((wr_ev & in_run) | start_ev | (en & timeout_hit & ~eoc_rise))
      err_next = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops      <= '0;
      mask     <= '0;
      result   <= '0;
      err      <= 1'b0;
      tcnt     <= '0;
      eoc_hist <= 1'b0;
    end else begin
      eoc_hist <= rsa_eoc;
      mask     <= mask_next;
      err      <= err_next;
      if (wr_ok)
        ops[sel] <= data_in;
      if (en && in_run && eoc_rise)
        result <= rsa_c;
      if (start_ok)
        tcnt <= '0;
      else if (in_run && tcnt != T_MAX)
        tcnt <= tcnt + TW'(1);
    end
  end

  assign busy         = in_run;
  assign rsa_en       = in_run;
  assign result_valid = (state == DONE);
  assign op_p         = ops[SEL_P];
  assign op_e         = ops[SEL_E];
  assign op_m         = ops[SEL_M];
  assign op_const     = ops[SEL_CONST];

endmodule

// File: tb/tb_rsa_operand_loader.sv
// Scoreboarded directed bench for rsa_operand_loader; a second instance uses a short timeout.
module tb_rsa_operand_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] data_in = '0;
  logic [1:0] sel = '0;
  logic       wr_strobe = 1'b0;
  logic       start_req = 1'b0;
  logic       rsa_eoc = 1'b0;
  logic [7:0] rsa_c = '0;

  logic [7:0] op_p, op_e, op_m, op_const, result;
  logic       rsa_en, result_valid, busy, err;
  logic [7:0] t_op_p, t_op_e, t_op_m, t_op_const, t_result;
  logic       t_rsa_en, t_result_valid, t_busy, t_err;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  logic       prev_rv = 1'b0;

  always #5 clk = ~clk;

  rsa_operand_loader dut (
    .clk(clk), .rst_n(rst_n), .en(en), .data_in(data_in), .sel(sel),
    .wr_strobe(wr_strobe), .start_req(start_req), .rsa_eoc(rsa_eoc), .rsa_c(rsa_c),
    .op_p(op_p), .op_e(op_e), .op_m(op_m), .op_const(op_const), .rsa_en(rsa_en),
    .result(result), .result_valid(result_valid), .busy(busy), .err(err)
  );

  rsa_operand_loader #(.TIMEOUT_CYCLES(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .en(en), .data_in(data_in), .sel(sel),
    .wr_strobe(wr_strobe), .start_req(start_req), .rsa_eoc(rsa_eoc), .rsa_c(rsa_c),
    .op_p(t_op_p), .op_e(t_op_e), .op_m(t_op_m), .op_const(t_op_const), .rsa_en(t_rsa_en),
    .result(t_result), .result_valid(t_result_valid), .busy(t_busy), .err(t_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Completion monitor: every rising result_valid must match the next queued result.
  always @(negedge clk) begin
    if (result_valid && !prev_rv) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got result 0x%0h with nothing expected", result);
      end else begin
        chk("sb_result", {24'd0, result}, {24'd0, exp_q.pop_front()});
        chk("sb_busy_low", {31'd0, busy}, 32'd0);
        chk("sb_rsa_en_low", {31'd0, rsa_en}, 32'd0);
      end
    end
    prev_rv = result_valid;
  end

  task automatic write_op(input logic [1:0] s, input logic [7:0] d);
    @(negedge clk);
    sel = s;
    data_in = d;
    wr_strobe = 1'b1;
    repeat (3) @(negedge clk);
    wr_strobe = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Returns at the negedge after the third rising clk edge following the pin rise.
  task automatic start_pulse(input bit early_chk);
    repeat (3) @(negedge clk);
    start_req = 1'b1;
    repeat (2) @(negedge clk);
    if (early_chk) chk("busy_before_edge3", {31'd0, busy}, 32'd0);
    @(negedge clk);
    start_req = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (result_valid) seen = 1;
    end
    chk("done_within_budget", {31'd0, seen}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_result", {24'd0, result}, 32'd0);
    chk("rst_valid", {31'd0, result_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;

    // Start with only P and E loaded
    write_op(2'd0, 8'h0B);
    write_op(2'd1, 8'h03);
    chk("op_p_loaded", {24'd0, op_p}, 32'h0B);
    chk("op_e_loaded", {24'd0, op_e}, 32'h03);
    start_pulse(1'b0);
    chk("partial_start_busy", {31'd0, busy}, 32'd0);
    chk("partial_start_err", {31'd0, err}, 32'd1);

    // Complete the load and run: eoc after 20 RUN cycles
    write_op(2'd2, 8'h05);
    write_op(2'd3, 8'h11);
    start_pulse(1'b1);
    chk("run_busy_edge3", {31'd0, busy}, 32'd1);
    chk("run_rsa_en_edge3", {31'd0, rsa_en}, 32'd1);
    chk("run_err_cleared", {31'd0, err}, 32'd0);
    repeat (20) @(negedge clk);
    chk("run1_still_busy", {31'd0, busy}, 32'd1);
    rsa_c = 8'h6E;
    rsa_eoc = 1'b1;
    exp_q.push_back(8'h6E);
    wait_done(8);
    chk("run1_err", {31'd0, err}, 32'd0);
    chk("short_timeout_err", {31'd0, t_err}, 32'd1);
    @(negedge clk);
    rsa_eoc = 1'b0;

    // Write during RUN is rejected; run still completes
    start_pulse(1'b0);
    chk("run2_busy", {31'd0, busy}, 32'd1);
    write_op(2'd1, 8'h99);
    chk("run_write_op_e", {24'd0, op_e}, 32'h03);
    chk("run_write_err", {31'd0, err}, 32'd1);
    chk("run_write_busy", {31'd0, busy}, 32'd1);
    rsa_c = 8'h5A;
    rsa_eoc = 1'b1;
    exp_q.push_back(8'h5A);
    wait_done(8);
    chk("run2_err_sticky", {31'd0, err}, 32'd1);
    chk("t_run2_result", {24'd0, t_result}, 32'h5A);
    chk("t_run2_valid", {31'd0, t_result_valid}, 32'd1);
    @(negedge clk);
    rsa_eoc = 1'b0;

    // Timeout on the 16-cycle instance
    start_pulse(1'b0);
    chk("t_start_err_clear", {31'd0, t_err}, 32'd0);
    repeat (15) @(negedge clk);
    chk("t_busy_cycle16", {31'd0, t_busy}, 32'd1);
    @(negedge clk);
    chk("t_timeout_busy", {31'd0, t_busy}, 32'd0);
    chk("t_timeout_rsa_en", {31'd0, t_rsa_en}, 32'd0);
    chk("t_timeout_err", {31'd0, t_err}, 32'd1);
    chk("t_timeout_result", {24'd0, t_result}, 32'h5A);
    chk("long_timeout_busy", {31'd0, busy}, 32'd1);
    rsa_c = 8'h3C;
    rsa_eoc = 1'b1;
    exp_q.push_back(8'h3C);
    wait_done(8);
    chk("t_eoc_in_idle_result", {24'd0, t_result}, 32'h5A);
    chk("t_eoc_in_idle_valid", {31'd0, t_result_valid}, 32'd0);
    @(negedge clk);
    rsa_eoc = 1'b0;

    // From DONE: rewrite M and start in the same cycle
    repeat (3) @(negedge clk);
    sel = 2'd2;
    data_in = 8'h07;
    wr_strobe = 1'b1;
    start_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("simul_op_m", {24'd0, op_m}, 32'h07);
    chk("simul_busy", {31'd0, busy}, 32'd1);
    chk("simul_valid", {31'd0, result_valid}, 32'd0);
    chk("simul_op_p", {24'd0, op_p}, 32'h0B);
    chk("simul_op_e", {24'd0, op_e}, 32'h03);
    chk("simul_op_const", {24'd0, op_const}, 32'h11);
    wr_strobe = 1'b0;
    start_req = 1'b0;
    repeat (3) @(negedge clk);

    // Asynchronous reset in the middle of a run
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_rsa_en", {31'd0, rsa_en}, 32'd0);
    chk("arst_result", {24'd0, result}, 32'd0);
    chk("arst_op_m", {24'd0, op_m}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start_pulse(1'b0);
    chk("post_reset_start_busy", {31'd0, busy}, 32'd0);
    chk("post_reset_start_err", {31'd0, err}, 32'd1);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
